uart_core: RTL and testbench

//   Full-duplex 8N1 UART byte engine: serialises one byte on tx_o per transmit_i

---
 rtl/uart_core_pkg.sv | 16 +
 rtl/uart_core_bit_timer.sv | 33 +++
 rtl/uart_core.sv | 163 ++++++++++++++++
 tb/tb_uart_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_core_pkg.sv
// Shared definitions for the UART byte engine: FSM state type and timer slot indices.
package uart_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned NUM_TIMERS = 2;
  localparam int unsigned TX_IDX     = 0;
  localparam int unsigned RX_IDX     = 1;

endpackage

// File: rtl/uart_core_bit_timer.sv
// Loadable bit-period down-counter; done_o is high once the loaded period has elapsed.
`timescale 1ns/1ps
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_full_i,
  input  logic load_half_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (load_full_i) begin
      cnt_reg <= FULL_LOAD;
    end else if (load_half_i) begin
      cnt_reg <= HALF_LOAD;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign done_o = (cnt_reg == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART byte engine with independent TX and RX state machines.
`timescale 1ns/1ps
module uart_core
  import uart_core_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       tx_o,
  input  logic       transmit_i,
  input  logic [7:0] tx_byte_i,
  output logic       received_o,
  output logic [7:0] rx_byte_o,
  output logic       is_receiving_o,
  output logic       is_transmitting_o,
  output logic       recv_error_o
);

  logic [NUM_TIMERS-1:0] tmr_full;
  logic [NUM_TIMERS-1:0] tmr_half;
  logic [NUM_TIMERS-1:0] tmr_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
      uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_full_i (tmr_full[gi]),
        .load_half_i (tmr_half[gi]),
        .done_o      (tmr_done[gi])
      );
    end
  endgenerate

  uart_state_e tx_state_reg;
  logic [7:0]  tx_shift_reg;
  logic [2:0]  tx_bit_reg;
  logic        tx_reg;
  logic        tx_busy_reg;

  assign tmr_full[TX_IDX] = ((tx_state_reg == ST_IDLE) && transmit_i) ||
                            ((tx_state_reg != ST_IDLE) && tmr_done[TX_IDX]);
  assign tmr_half[TX_IDX] = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_reg <= ST_IDLE;
      tx_shift_reg <= '0;
      tx_bit_reg   <= '0;
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        ST_IDLE: if (transmit_i) begin
          tx_shift_reg <= tx_byte_i;
          tx_reg       <= 1'b0;
          tx_busy_reg  <= 1'b1;
          tx_state_reg <= ST_START;
        end
        ST_START: if (tmr_done[TX_IDX]) begin
          tx_reg       <= tx_shift_reg[0];
          tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
          tx_bit_reg   <= '0;
          tx_state_reg <= ST_DATA;
        end
        ST_DATA: if (tmr_done[TX_IDX]) begin
          if (tx_bit_reg == 3'(DATA_BITS - 1)) begin
            tx_reg       <= 1'b1;
            tx_state_reg <= ST_STOP;
          end else begin
            tx_reg       <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_bit_reg   <= tx_bit_reg + 3'd1;
          end
        end
        ST_STOP: if (tmr_done[TX_IDX]) begin
          tx_busy_reg  <= 1'b0;
          tx_state_reg <= ST_IDLE;
        end
        default: tx_state_reg <= ST_IDLE;
      endcase
    end
  end

  uart_state_e rx_state_reg;
  logic        rx_meta_reg;
  logic        rx_sync_reg;
  logic [7:0]  rx_shift_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_byte_reg;
  logic        rx_busy_reg;
  logic        rx_done_reg;
  logic        rx_err_reg;
  logic        rx_wait_high_reg;

  assign tmr_half[RX_IDX] = (rx_state_reg == ST_IDLE) && !rx_wait_high_reg && !rx_sync_reg;
  assign tmr_full[RX_IDX] = (rx_state_reg != ST_IDLE) && tmr_done[RX_IDX];

  // After a bad stop bit the line may be in break; wait for it to return high before re-arming.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_reg      <= 1'b1;
      rx_sync_reg      <= 1'b1;
      rx_state_reg     <= ST_IDLE;
      rx_shift_reg     <= '0;
      rx_bit_reg       <= '0;
      rx_byte_reg      <= '0;
      rx_busy_reg      <= 1'b0;
      rx_done_reg      <= 1'b0;
      rx_err_reg       <= 1'b0;
      rx_wait_high_reg <= 1'b0;
    end else begin
      rx_meta_reg <= rx_i;
      rx_sync_reg <= rx_meta_reg;
      rx_done_reg <= 1'b0;
      rx_err_reg  <= 1'b0;
      case (rx_state_reg)
        ST_IDLE: begin
          if (rx_wait_high_reg) begin
            if (rx_sync_reg) rx_wait_high_reg <= 1'b0;
          end else if (!rx_sync_reg) begin
            rx_busy_reg  <= 1'b1;
            rx_state_reg <= ST_START;
          end
        end
        ST_START: if (tmr_done[RX_IDX]) begin
          if (rx_sync_reg) begin
            rx_busy_reg  <= 1'b0;
            rx_state_reg <= ST_IDLE;
          end else begin
            rx_bit_reg   <= '0;
            rx_state_reg <= ST_DATA;
          end
        end
        ST_DATA: if (tmr_done[RX_IDX]) begin
          rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'(DATA_BITS - 1)) rx_state_reg <= ST_STOP;
          else                                 rx_bit_reg   <= rx_bit_reg + 3'd1;
        end
        ST_STOP: if (tmr_done[RX_IDX]) begin
          rx_byte_reg      <= rx_shift_reg;
          rx_done_reg      <= 1'b1;
          rx_err_reg       <= !rx_sync_reg;
          rx_wait_high_reg <= !rx_sync_reg;
          rx_busy_reg      <= 1'b0;
          rx_state_reg     <= ST_IDLE;
        end
        default: rx_state_reg <= ST_IDLE;
      endcase
    end
  end

  assign tx_o              = tx_reg;
  assign is_transmitting_o = tx_busy_reg;
  assign received_o        = rx_done_reg;
  assign recv_error_o      = rx_err_reg;
  assign rx_byte_o         = rx_byte_reg;
  assign is_receiving_o    = rx_busy_reg;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: directed TX/RX frames checked by independent monitors.
`timescale 1ns/1ps
module tb_uart_core;

  localparam int unsigned CPB = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic       transmit_i = 1'b0;
  logic [7:0] tx_byte_i = 8'h00;
  logic       tx_o;
  logic       received_o;
  logic [7:0] rx_byte_o;
  logic       is_receiving_o;
  logic       is_transmitting_o;
  logic       recv_error_o;

  always #5 clk_i = ~clk_i;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .rx_i              (rx_i),
    .tx_o              (tx_o),
    .transmit_i        (transmit_i),
    .tx_byte_i         (tx_byte_i),
    .received_o        (received_o),
    .rx_byte_o         (rx_byte_o),
    .is_receiving_o    (is_receiving_o),
    .is_transmitting_o (is_transmitting_o),
    .recv_error_o      (recv_error_o)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [8:0] rx_q[$];   // {expected error, expected byte}

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    transmit_i = 1'b1;
    tx_byte_i  = b;
    @(negedge clk_i);
    transmit_i = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int c = 0;
    while (is_transmitting_o && c < 300) begin
      @(negedge clk_i);
      c++;
    end
    if (c >= 300) begin
      checks++;
      errors++;
      $display("FAIL tx_idle_timeout: got busy after %0d cycles required idle", c);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk_i);
  endtask

  // TX monitor: capture each frame cycle by cycle and decode it independently.
  initial begin : tx_mon
    logic       tx_s [0:199];
    int         n;
    bit         aborted;
    bit         hold_ok;
    logic [9:0] frame;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk_i);
      if (rst_ni && is_transmitting_o) begin
        aborted = 1'b0;
        tx_s[0] = tx_o;
        n = 1;
        while (n < 200) begin
          @(negedge clk_i);
          if (!rst_ni) begin
            aborted = 1'b1;
            break;
          end
          if (!is_transmitting_o) break;
          tx_s[n] = tx_o;
          n++;
        end
        if (!aborted) begin
          check("tx_busy_cycles", 32'(n), 10 * CPB);
          hold_ok = 1'b1;
          frame = '0;
          for (int b = 0; b < 10; b++) begin
            frame[b] = tx_s[b*CPB];
            for (int j = 1; j < int'(CPB); j++)
              if (tx_s[b*CPB+j] !== frame[b]) hold_ok = 1'b0;
          end
          check("tx_bit_hold", 32'(hold_ok), 1);
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_frame: got frame 0x%03h required no frame", frame);
          end else begin
            exp_b = tx_q.pop_front();
            check("tx_frame", 32'(frame), 32'({1'b1, exp_b, 1'b0}));
            $display("tx frame data 0x%02h expected 0x%02h", frame[8:1], exp_b);
          end
          check("tx_idle_level", 32'(tx_o), 1);
        end
      end
    end
  end

  // RX monitor: every completion strobe is matched against the next expected frame.
  initial begin : rx_mon
    logic [8:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && recv_error_o && !received_o) begin
        checks++;
        errors++;
        $display("FAIL rx_error_alone: got recv_error_o=1 received_o=0 required both");
      end
      if (rst_ni && received_o) begin
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_frame: got byte 0x%02h err %0d required no frame",
                   rx_byte_o, recv_error_o);
        end else begin
          e = rx_q.pop_front();
          check("rx_byte", 32'(rx_byte_o), 32'(e[7:0]));
          check("rx_error", 32'(recv_error_o), 32'(e[8]));
          check("rx_busy_fall", 32'(is_receiving_o), 0);
          $display("rx frame byte 0x%02h err %0d expected 0x%02h err %0d",
                   rx_byte_o, recv_error_o, e[7:0], e[8]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit seen;
    repeat (3) @(negedge clk_i);
    check("rst_tx_o", 32'(tx_o), 1);
    check("rst_tx_busy", 32'(is_transmitting_o), 0);
    check("rst_rx_busy", 32'(is_receiving_o), 0);
    check("rst_rx_byte", 32'(rx_byte_o), 0);
    check("rst_received", 32'(received_o), 0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    // Reset in the middle of a TX frame
    tx_send(8'h77);
    repeat (20) @(negedge clk_i);
    check("midframe_busy", 32'(is_transmitting_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_tx_o", 32'(tx_o), 1);
    check("async_rst_tx_busy", 32'(is_transmitting_o), 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    check("post_rst_tx_o", 32'(tx_o), 1);
    check("post_rst_tx_busy", 32'(is_transmitting_o), 0);
    check("post_rst_rx_busy", 32'(is_receiving_o), 0);

    // TX 0xA5 followed by a back-to-back 0xC3 in the first idle cycle
    tx_q.push_back(8'hA5);
    tx_send(8'hA5);
    wait_tx_idle();
    tx_q.push_back(8'hC3);
    tx_send(8'hC3);
    wait_tx_idle();
    repeat (4) @(negedge clk_i);

    // RX 0x3C then 0x81 with zero inter-frame gap
    rx_q.push_back({1'b0, 8'h3C});
    rx_q.push_back({1'b0, 8'h81});
    send_rx(8'h3C, 1'b1);
    send_rx(8'h81, 1'b1);
    repeat (20) @(negedge clk_i);

    // Bad stop bit on 0x55, then line held in break
    rx_q.push_back({1'b1, 8'h55});
    send_rx(8'h55, 1'b0);
    repeat (40) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (20) @(negedge clk_i);

    // Two-cycle glitch must be rejected at mid-start
    rx_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rx_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (is_receiving_o) seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen), 1);
    check("glitch_busy_clear", 32'(is_receiving_o), 0);
    repeat (10) @(negedge clk_i);

    // TX 0x41 during RX 0x42; a request while busy must be dropped
    tx_q.push_back(8'h41);
    rx_q.push_back({1'b0, 8'h42});
    fork
      send_rx(8'h42, 1'b1);
      begin
        repeat (20) @(negedge clk_i);
        tx_send(8'h41);
        repeat (30) @(negedge clk_i);
        tx_send(8'h99);
      end
    join
    wait_tx_idle();
    repeat (120) @(negedge clk_i);

    check("tx_queue_drained", 32'(tx_q.size()), 0);
    check("rx_queue_drained", 32'(rx_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
